ov2640_sccb_config: RTL and testbench

Sequencer and SCCB write master for OV2640 camera bring-up. It consumes the 16-bit {register, value} command stream from the camera register table and drives the table's resend/advance inputs. Each command is sent as a 3-phase SCCB write (device ID, register, value) on SIOC/SIOD, until the table reports finished. It sits between the register table and the camera pins in the ov2640 capture subsystem.

---
 rtl/ov2640_pkg.sv | 13 +
 rtl/ov2640_sccb_config_phy.sv | 108 ++++++++++
 rtl/ov2640_sccb_config.sv | 124 ++++++++++++
 tb/tb_ov2640_sccb_config.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ov2640_pkg.sv
// ov2640_pkg: shared types and constants for the OV2640 SCCB configuration block.
package ov2640_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_REWIND, S_SETTLE, S_CHECK, S_START,
        S_SHIFT, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;
    typedef enum logic [1:0] {P_IDLE, P_START, P_SHIFT, P_STOP} phase_t;
    localparam int SCCB_FRAME_BITS = 27;
    localparam logic [15:0] CMD_END = 16'hFFFF;
    localparam logic [7:0] REG_COM7 = 8'h12;
    localparam int COM7_SRST = 7;
    localparam logic [7:0] DEV_ID_DEFAULT = 8'h60;
endpackage

// File: rtl/ov2640_sccb_config_phy.sv
// sccb_write_phy: START, 27-bit MSB-first shift and STOP on SIOC/SIOD, paced by a quarter-bit tick.
module sccb_write_phy
    import ov2640_pkg::*;
#(
    parameter int QTR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go_i,
    input  logic                       abort_i,
    input  logic [SCCB_FRAME_BITS-1:0] frame_i,
    output logic                       sioc_o,
    output logic                       siod_oe_o,
    output logic                       ready_o,
    output logic [1:0]                 phase_o
);
    localparam int QW = $clog2(QTR);
    phase_t phase_q, phase_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0] qidx_q, qidx_d;
    logic [4:0] bcnt_q, bcnt_d;
    logic [SCCB_FRAME_BITS-1:0] sh_q, sh_d;
    logic sioc_q, sioc_d, oe_q, oe_d;
    logic tick;
    assign tick = qcnt_q == QW'(QTR - 1);
    always_comb begin
        phase_d = phase_q;
        qcnt_d  = qcnt_q;
        qidx_d  = qidx_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        sioc_d  = sioc_q;
        oe_d    = oe_q;
        if (abort_i) begin
            phase_d = P_IDLE;
            qcnt_d  = '0;
            sioc_d  = 1'b1;
            oe_d    = 1'b0;
        end else if (phase_q == P_IDLE) begin
            if (go_i) begin
                phase_d = P_START;
                sh_d    = frame_i;
                bcnt_d  = '0;
                qidx_d  = '0;
                qcnt_d  = '0;
                sioc_d  = 1'b1;
                oe_d    = 1'b1;
            end
        end else if (!tick) begin
            qcnt_d = qcnt_q + QW'(1);
        end else begin
            qcnt_d = '0;
            qidx_d = qidx_q + 2'd1;
            case (phase_q)
                P_START: begin
                    phase_d = P_SHIFT;
                    qidx_d  = '0;
                    sioc_d  = 1'b0;
                    oe_d    = ~sh_q[SCCB_FRAME_BITS-1];
                end
                P_SHIFT: begin
                    sioc_d = qidx_q != 2'd0;
                    // Bit boundary: SIOC drops and the next bit is placed in the same quarter.
                    if (qidx_q == 2'd3) begin
                        sioc_d = 1'b0;
                        if (bcnt_q == 5'(SCCB_FRAME_BITS - 1)) begin
                            phase_d = P_STOP;
                            oe_d    = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + 5'd1;
                            sh_d   = {sh_q[SCCB_FRAME_BITS-2:0], 1'b0};
                            oe_d   = ~sh_q[SCCB_FRAME_BITS-2];
                        end
                    end
                end
                P_STOP: begin
                    sioc_d  = 1'b1;
                    oe_d    = qidx_q == 2'd0;
                    phase_d = qidx_q == 2'd2 ? P_IDLE : P_STOP;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= P_IDLE;
            qcnt_q  <= '0;
            qidx_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            sioc_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            qcnt_q  <= qcnt_d;
            qidx_q  <= qidx_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            sioc_q  <= sioc_d;
            oe_q    <= oe_d;
        end
    end
    assign sioc_o    = sioc_q;
    assign siod_oe_o = oe_q;
    assign ready_o   = phase_q == P_IDLE;
    assign phase_o   = phase_q;
endmodule

// File: rtl/ov2640_sccb_config.sv
// ov2640_sccb_config: walks the camera register table and writes each {reg, val} over SCCB.
module ov2640_sccb_config
    import ov2640_pkg::*;
#(
    parameter int         CLK_FREQ_HZ   = 27_000_000,
    parameter int         SCCB_FREQ_HZ  = 100_000,
    parameter logic [7:0] DEV_ID        = DEV_ID_DEFAULT,
    parameter int         RST_DELAY_CYC = 27_000,
    parameter int         GAP_CYC       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        sioc,
    output logic        siod_oe,
    output logic        busy,
    output logic        done
);
    localparam int QTR  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int DMAX = RST_DELAY_CYC > GAP_CYC ? RST_DELAY_CYC : GAP_CYC;
    localparam int DW   = $clog2(DMAX + 1);
    state_t state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic resend_q, resend_d, advance_q, advance_d;
    logic busy_q, busy_d, done_q, done_d, srst_q, srst_d;
    logic go, phy_ready;
    logic [1:0] phy_phase;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        resend_d  = 1'b0;
        advance_d = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        srst_d    = srst_q;
        go        = 1'b0;
        if (start) begin
            state_d  = S_REWIND;
            resend_d = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                S_REWIND: begin
                    state_d = S_SETTLE;
                    cnt_d   = DW'(1);
                end
                S_SETTLE: begin
                    state_d = cnt_q == '0 ? S_CHECK : S_SETTLE;
                    cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - DW'(1);
                end
                S_CHECK: begin
                    if (finished) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        go      = 1'b1;
                        srst_d  = command[15:8] == REG_COM7 && command[COM7_SRST];
                        state_d = S_START;
                    end
                end
                S_START, S_SHIFT, S_STOP: begin
                    // The cycle that observes the PHY idle is the first idle clock of the gap.
                    if (phy_ready) begin
                        state_d = srst_q ? S_DELAY : S_GAP;
                        cnt_d   = srst_q ? DW'(RST_DELAY_CYC - 2) : DW'(GAP_CYC - 2);
                    end else begin
                        state_d = phase_t'(phy_phase) == P_SHIFT ? S_SHIFT :
                                  phase_t'(phy_phase) == P_STOP  ? S_STOP  : S_START;
                    end
                end
                S_GAP, S_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d   = S_SETTLE;
                        advance_d = 1'b1;
                        cnt_d     = DW'(1);
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            resend_q  <= 1'b0;
            advance_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            srst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            resend_q  <= resend_d;
            advance_q <= advance_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            srst_q    <= srst_d;
        end
    end
    sccb_write_phy #(.QTR(QTR)) u_phy (
        .clk      (clk),
        .rst      (rst),
        .go_i     (go),
        .abort_i  (start),
        .frame_i  ({DEV_ID, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1}),
        .sioc_o   (sioc),
        .siod_oe_o(siod_oe),
        .ready_o  (phy_ready),
        .phase_o  (phy_phase)
    );
    assign resend  = resend_q;
    assign advance = advance_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_ov2640_sccb_config.sv
// tb_ov2640_sccb_config: directed scenarios against a register-table model and an SCCB pin decoder.
module tb_ov2640_sccb_config;
    import ov2640_pkg::*;
    localparam int QTR = 2;
    localparam int GAP = 4;
    localparam int RSTD = 20;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] command;
    logic finished, resend, advance, sioc, siod_oe, busy, done;
    logic [15:0] tbl [8];
    int idx = 0;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_res = 0, n_adv = 0, n_both = 0, n_fall = 0, n_rise = 0, n_tog = 0, rel_cyc = 0;
    logic ps = 1'b1, po = 1'b0;
    logic bits [$];
    int gaps [$];

    always #5 clk = ~clk;

    ov2640_sccb_config #(
        .CLK_FREQ_HZ(800), .SCCB_FREQ_HZ(100), .DEV_ID(8'h60),
        .RST_DELAY_CYC(RSTD), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .command(command), .finished(finished),
        .resend(resend), .advance(advance), .sioc(sioc), .siod_oe(siod_oe),
        .busy(busy), .done(done)
    );

    // Register table model: index rewinds on resend, steps on advance, output one clock later.
    always @(posedge clk) idx <= resend ? 0 : (advance && idx < 7) ? idx + 1 : idx;
    assign command  = tbl[idx];
    assign finished = command == CMD_END;

    always @(negedge clk) begin
        if (!rst) begin
            if (sioc !== ps) n_tog++;
            if (sioc && !ps) bits.push_back(!siod_oe);
            if (sioc && ps && siod_oe && !po) n_fall++;
            if (sioc && ps && !siod_oe && po) begin n_rise++; rel_cyc = cyc; end
            if (resend) n_res++;
            if (advance) begin n_adv++; gaps.push_back(cyc - rel_cyc - QTR); end
            if (resend && advance) n_both++;
        end
        ps = sioc;
        po = siod_oe;
        cyc++;
    end

    function automatic logic [26:0] frame_at(int k);
        logic [26:0] f;
        if (bits.size() < 28 * (k + 1)) return 'x;
        for (int i = 0; i < 27; i++) f[26 - i] = bits[28 * k + i];
        return f;
    endfunction

    task automatic clear_mon();
        bits.delete(); gaps.delete();
        n_res = 0; n_adv = 0; n_both = 0; n_fall = 0; n_rise = 0; n_tog = 0;
    endtask

    task automatic load_tbl(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 8; i++) tbl[i] = CMD_END;
        tbl[0] = a; tbl[1] = b; tbl[2] = c;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (sioc !== 1'b1) begin n_fail++; $display("FAIL reset_sioc got=%b want=1", sioc); end
        n_checks++; if (siod_oe !== 1'b0) begin n_fail++; $display("FAIL reset_siod_oe got=%b want=0", siod_oe); end
        n_checks++; if (resend !== 1'b0 || advance !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b want=00", resend, advance); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_status got=%b%b want=00", busy, done); end
    endtask

    task automatic test_two_frames();
        bit ok;
        load_tbl(16'h1280, 16'hFF00, CMD_END);
        clear_mon();
        pulse_start();
        n_checks++; if (resend !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL start_accept got resend=%b busy=%b done=%b want 1 1 0", resend, busy, done); end
        wait_done(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_done_timeout got=0 want=1"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_busy got=%b want=0", busy); end
        n_checks++; if (n_res !== 1) begin n_fail++; $display("FAIL two_resend_count got=%0d want=1", n_res); end
        n_checks++; if (n_adv !== 2) begin n_fail++; $display("FAIL two_advance_count got=%0d want=2", n_adv); end
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL two_overlap got=%0d want=0", n_both); end
        n_checks++; if (bits.size() !== 56) begin n_fail++; $display("FAIL two_sioc_edges got=%0d want=56", bits.size()); end
        n_checks++; if (frame_at(0) !== {8'h60, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}) begin n_fail++; $display("FAIL frame0 got=%h want=%h", frame_at(0), {8'h60, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}); end
        n_checks++; if (frame_at(1) !== {8'h60, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1}) begin n_fail++; $display("FAIL frame1 got=%h want=%h", frame_at(1), {8'h60, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1}); end
        n_checks++; if (n_fall !== 2 || n_rise !== 2) begin n_fail++; $display("FAIL two_siod_while_sioc_high got fall=%0d rise=%0d want 2 2", n_fall, n_rise); end
        n_checks++; if (gaps.size() < 1 || gaps[0] !== RSTD) begin n_fail++; $display("FAIL srst_delay got=%0d want=%0d", gaps.size() > 0 ? gaps[0] : -1, RSTD); end
        n_checks++; if (gaps.size() < 2 || gaps[1] !== GAP) begin n_fail++; $display("FAIL bank_gap got=%0d want=%0d", gaps.size() > 1 ? gaps[1] : -1, GAP); end
    endtask

    task automatic test_empty();
        int k;
        load_tbl(CMD_END, CMD_END, CMD_END);
        clear_mon();
        pulse_start();
        k = 0;
        while (!done && k < 10) begin @(posedge clk); #1; k++; end
        n_checks++; if (done !== 1'b1 || k > 4) begin n_fail++; $display("FAIL empty_done got done=%b after %0d clks want 1 within 4", done, k); end
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (n_tog !== 0) begin n_fail++; $display("FAIL empty_sioc_toggles got=%0d want=0", n_tog); end
        n_checks++; if (n_adv !== 0) begin n_fail++; $display("FAIL empty_advance got=%0d want=0", n_adv); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy got=%b want=0", busy); end
    endtask

    task automatic test_abort();
        bit ok;
        int k;
        load_tbl(16'hFF00, 16'h1240, CMD_END);
        clear_mon();
        pulse_start();
        k = 0;
        while (bits.size() < 38 && k < 2000) begin @(negedge clk); k++; end
        while (sioc && k < 2000) begin @(negedge clk); k++; end
        n_checks++; if (k >= 2000 || siod_oe !== 1'b1) begin n_fail++; $display("FAIL abort_reach_bit10 got k=%0d oe=%b want k<2000 oe=1", k, siod_oe); end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++; if (sioc !== 1'b1 || siod_oe !== 1'b0) begin n_fail++; $display("FAIL abort_release got sioc=%b oe=%b want 1 0", sioc, siod_oe); end
        n_checks++; if (resend !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_resend got resend=%b busy=%b want 1 1", resend, busy); end
        @(negedge clk); #1;
        clear_mon();
        wait_done(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_done_timeout got=0 want=1"); end
        n_checks++; if (n_adv !== 2) begin n_fail++; $display("FAIL abort_advance_count got=%0d want=2", n_adv); end
        n_checks++; if (frame_at(0) !== {8'h60, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1}) begin n_fail++; $display("FAIL abort_frame0 got=%h want=%h", frame_at(0), {8'h60, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1}); end
        n_checks++; if (frame_at(1) !== {8'h60, 1'b1, 8'h12, 1'b1, 8'h40, 1'b1}) begin n_fail++; $display("FAIL abort_frame1 got=%h want=%h", frame_at(1), {8'h60, 1'b1, 8'h12, 1'b1, 8'h40, 1'b1}); end
        n_checks++; if (gaps.size() < 2 || gaps[1] !== GAP) begin n_fail++; $display("FAIL srst_clear_gap got=%0d want=%0d", gaps.size() > 1 ? gaps[1] : -1, GAP); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int k;
        load_tbl(16'h1280, CMD_END, CMD_END);
        clear_mon();
        pulse_start();
        k = 0;
        while (bits.size() < 5 && k < 2000) begin @(negedge clk); k++; end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_checks++; if (sioc !== 1'b1 || siod_oe !== 1'b0) begin n_fail++; $display("FAIL async_rst_bus got sioc=%b oe=%b want 1 0", sioc, siod_oe); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_rst_status got busy=%b done=%b want 0 0", busy, done); end
        @(posedge clk); #1 rst = 1'b0;
        clear_mon();
        pulse_start();
        wait_done(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_rerun_timeout got=0 want=1"); end
        n_checks++; if (n_adv !== 1) begin n_fail++; $display("FAIL rst_rerun_advance got=%0d want=1", n_adv); end
        n_checks++; if (frame_at(0) !== {8'h60, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}) begin n_fail++; $display("FAIL rst_rerun_frame got=%h want=%h", frame_at(0), {8'h60, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}); end
    endtask

    initial begin
        load_tbl(CMD_END, CMD_END, CMD_END);
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1 rst = 1'b0;
        test_two_frames();
        test_empty();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
